alu_issue_ctrl: RTL and testbench

// - Issuing/collecting end of the 32-bit logical/shift ALU interface (in1, in2, sel2..sel0 -> out).
// - Buffers operation commands in a small FIFO, drives the ALU operands and selects, holds them

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_cmd_fifo.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 99 +++++++++
 tb/tb_alu_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode legality check shared by the ALU issue controller.
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    // Only the two encodings with sel1=sel0=1 (011, 111) have no ALU function.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO with combinational head read.
//   clk, rst_n     clock, async active-low reset
//   push, wdata    write the entry (caller guarantees !full)
//   pop, rdata     rdata is the current head; pop advances it (caller guarantees !empty)
//   full, empty    occupancy flags
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // Storage needs no reset: reset empties the FIFO through the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, issues one at a time to an external ALU and returns results.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b   command input (valid/ready)
//   alu_in1/alu_in2/alu_sel                  registered operands/select to the ALU
//   alu_out                                  ALU result, sampled ALU_LAT cycles after issue
//   res_valid/res_ready/res_data/res_op/res_err  result output (valid/ready)
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             res_err
);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             push, pop, full, empty;
    logic [2:0]       h_op;
    logic [WIDTH-1:0] h_a, h_b;
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == ST_IDLE && !empty;
    alu_cmd_fifo #(.DEPTH(DEPTH), .DW(3 + 2 * WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cmd_op, cmd_a, cmd_b}),
        .pop   (pop),
        .rdata ({h_op, h_a, h_b}),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_sel   <= OP_AND;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= OP_AND;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop && op_is_legal(h_op)) begin
                        alu_in1 <= h_a;
                        alu_in2 <= h_b;
                        alu_sel <= h_op;
                        cnt     <= '0;
                        state   <= ST_ISSUE;
                    end else if (pop) begin
                        // Illegal ops bypass the ALU so alu_sel never carries an undefined code.
                        res_data  <= '0;
                        res_op    <= h_op;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ALU_LAT - 1)) begin
                        res_data  <= alu_out;
                        res_op    <= alu_sel;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a queue-based result model for alu_issue_ctrl and a behavioural ALU.
module tb_alu_issue_ctrl;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] d;
        logic        e;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_sel;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_data;
    logic [2:0]  res_op;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    res_t exp_q[$];
    res_t log_q[$];
    int   hs_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b110:  return a << b[4:0];
            3'b100:  return $signed(a) >>> b[4:0];
            3'b101:  return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r.op = op;
        r.e  = op == 3'b011 || op == 3'b111;
        r.d  = r.e ? 32'h0 : alu_f(op, a, b);
        return r;
    endfunction

    assign alu_out = alu_f(alu_sel, alu_in1, alu_in2);

    alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(1), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (!rst_n) exp_q.delete();
        else begin
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
            chk("alu_sel_legal", {63'b0, alu_sel[1:0] == 2'b11}, 64'd0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) fail("res_unexpected");
                else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("res_data", {32'b0, res_data}, {32'b0, e.d});
                    chk("res_op", {61'b0, res_op}, {61'b0, e.op});
                    chk("res_err", {63'b0, res_err}, {63'b0, e.e});
                    log_q.push_back('{op: res_op, d: res_data, e: res_err});
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 200);
        if (!cmd_ready) fail("send_timeout");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #2 k++;
        end while (exp_q.size() != 0 && k < 300);
        if (exp_q.size() != 0) fail(nm);
    endtask

    initial begin
        int b0, n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_a = 32'h0; cmd_b = 32'h0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        chk("rst_res_valid", {63'b0, res_valid}, 64'd0);
        chk("rst_res_err", {63'b0, res_err}, 64'd0);
        chk("rst_alu_in1", {32'b0, alu_in1}, 64'd0);
        chk("rst_alu_in2", {32'b0, alu_in2}, 64'd0);
        chk("rst_alu_sel", {61'b0, alu_sel}, 64'd0);
        chk("rst_res_data", {32'b0, res_data}, 64'd0);
        chk("rst_res_op", {61'b0, res_op}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(3'b000, 32'h1, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid_n1", {63'b0, res_valid}, 64'd0);
        @(negedge clk);
        chk("t1_valid_n2", {63'b0, res_valid}, 64'd1);
        chk("t1_data", {32'b0, res_data}, 64'h1);
        chk("t1_op", {61'b0, res_op}, 64'd0);
        chk("t1_err", {63'b0, res_err}, 64'd0);
        drain("t1_drain");

        send(3'b001, 32'h1, 32'h1);
        send(3'b010, 32'h1, 32'h0);
        send(3'b110, 32'h30, 32'h0);
        drain("t2_drain");
        n = log_q.size();
        chk("t2_op0", {61'b0, log_q[n-3].op}, 64'd1);
        chk("t2_op1", {61'b0, log_q[n-2].op}, 64'd2);
        chk("t2_op2", {61'b0, log_q[n-1].op}, 64'd6);
        chk("t2_sll", {32'b0, log_q[n-1].d}, 64'h30);
        chk("t2_gap01", 64'(hs_cyc[n-2] - hs_cyc[n-3]), 64'd3);
        chk("t2_gap12", 64'(hs_cyc[n-1] - hs_cyc[n-2]), 64'd3);

        res_ready = 1'b0;
        b0 = log_q.size();
        send(3'b000, 32'hFF00FF00, 32'h0F0F0F0F);
        send(3'b001, 32'h1, 32'h2);
        send(3'b010, 32'hFFFF, 32'hF0F0);
        send(3'b110, 32'h3, 32'h4);
        send(3'b101, 32'h100, 32'h4);
        @(negedge clk);
        chk("t3_cmd_ready_full", {63'b0, cmd_ready}, 64'd0);
        chk("t3_hold_valid", {63'b0, res_valid}, 64'd1);
        chk("t3_hold_data", {32'b0, res_data}, 64'h0F000F00);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain("t3_drain");
        chk("t3_count", 64'(log_q.size() - b0), 64'd5);

        send(3'b100, 32'hF, 32'h0);
        send(3'b011, 32'h5, 32'h6);
        send(3'b101, 32'hA, 32'h0);
        drain("t4_drain");
        n = log_q.size();
        chk("t4_sra", {32'b0, log_q[n-3].d}, 64'hF);
        chk("t4_err_mid", {63'b0, log_q[n-2].e}, 64'd1);
        chk("t4_data_mid", {32'b0, log_q[n-2].d}, 64'd0);
        chk("t4_op_mid", {61'b0, log_q[n-2].op}, 64'd3);
        chk("t4_srl", {32'b0, log_q[n-1].d}, 64'hA);
        chk("t4_err_srl", {63'b0, log_q[n-1].e}, 64'd0);

        res_ready = 1'b0;
        send(3'b000, 32'h11, 32'hFF);
        send(3'b001, 32'h22, 32'h0);
        send(3'b010, 32'h33, 32'h0);
        send(3'b110, 32'h44, 32'h0);
        res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("t5_in_issue", {32'b0, alu_in1}, 64'h22);
        b0 = log_q.size();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {63'b0, res_valid}, 64'd0);
        chk("t5_rst_ready", {63'b0, cmd_ready}, 64'd1);
        chk("t5_rst_in1", {32'b0, alu_in1}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #2 chk("t5_no_stale", 64'(log_q.size() - b0), 64'd0);

        res_ready = 1'b0;
        b0 = log_q.size();
        send(3'b100, 32'h80000000, 32'h4);
        send(3'b110, 32'h1, 32'd31);
        send(3'b101, 32'h80000000, 32'd31);
        send(3'b010, 32'hAAAA5555, 32'hFFFF0000);
        send(3'b111, 32'h1, 32'h1);
        res_ready = 1'b1;
        send(3'b000, 32'h7, 32'h5);
        send(3'b001, 32'h8, 32'h1);
        send(3'b100, 32'hF0, 32'h4);
        send(3'b110, 32'h5, 32'h1);
        send(3'b011, 32'h9, 32'h9);
        send(3'b010, 32'h3, 32'h3);
        drain("t6_drain");
        chk("t6_count", 64'(log_q.size() - b0), 64'd11);
        chk("t6_sra_neg", {32'b0, log_q[b0].d}, 64'hF8000000);
        chk("t6_sll31", {32'b0, log_q[b0+1].d}, 64'h80000000);
        chk("t6_srl31", {32'b0, log_q[b0+2].d}, 64'h1);
        chk("t6_xor", {32'b0, log_q[b0+3].d}, 64'h55555555);
        chk("t6_err_111", {63'b0, log_q[b0+4].e}, 64'd1);
        chk("t6_last_op", {61'b0, log_q[b0+10].op}, 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
